// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: command ops, register control codes
// and the sequencer state enum.
package shift_seq_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_SHR  = 2'b01;
    localparam logic [1:0] CTRL_SHL  = 2'b10;
    localparam logic [1:0] CTRL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/shift_seq_counter.sv
// Down counter for shift cycles: parallel load, saturating decrement, and a
// flag marking the last remaining cycle.
module shift_seq_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    // Decrement stops at zero so an extra i_dec can never wrap the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer that drives a universal shift register through LOAD,
// SHR, SHL and ROTR operations, one accepted command at a time.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] reg_q,
    output logic [1:0]       control,
    output logic [WIDTH-1:0] data_in,
    output logic             shift_in_left,
    output logic             shift_in_right,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic             r_fill;
    logic             r_ready_en;
    logic             w_hs;
    logic             w_last;
    logic [CNT_W-1:0] w_eff;
    logic             w_unused_q;

    function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] c);
        if (c > W_CNT) begin
            return W_CNT;
        end
        return c;
    endfunction

    assign w_eff      = eff_count(cmd_count);
    assign w_hs       = cmd_valid && cmd_ready;
    assign w_unused_q = ^reg_q[WIDTH-1:1];

    // r_ready_en holds cmd_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_LOAD;
            r_data     <= '0;
            r_fill     <= 1'b0;
            r_ready_en <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ready_en <= 1'b1;
            if (w_hs) begin
                r_op   <= cmd_op;
                r_data <= cmd_data;
                r_fill <= cmd_fill;
            end
        end
    end

    shift_seq_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_hs),
        .i_load_val (w_eff),
        .i_dec      (r_state == ST_SHIFT),
        .o_last     (w_last)
    );

    always_comb begin
        w_next         = r_state;
        control        = CTRL_HOLD;
        data_in        = '0;
        shift_in_left  = 1'b0;
        shift_in_right = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    if (cmd_op == OP_LOAD)  w_next = ST_LOAD;
                    else if (w_eff == '0)   w_next = ST_DONE;
                    else                    w_next = ST_SHIFT;
                end
            end
            ST_LOAD: begin
                control = CTRL_LOAD;
                data_in = r_data;
                w_next  = ST_DONE;
            end
            ST_SHIFT: begin
                control = (r_op == OP_SHL) ? CTRL_SHL : CTRL_SHR;
                // Rotation feeds the live LSB back in, so it bypasses the captured fill.
                if (r_op == OP_ROTR) begin
                    shift_in_right = reg_q[0];
                end else begin
                    shift_in_left  = r_fill;
                    shift_in_right = r_fill;
                end
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = (r_state == ST_IDLE) && r_ready_en;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer driving a behavioural universal shift register,
// with a scoreboard of expected results checked at each done pulse.
module tb_shift_sequencer;

    typedef struct {
        logic [1:0] op;
        logic [3:0] cnt;
        logic [7:0] data;
        logic       fill;
        logic [1:0] ctrl;
        logic [7:0] exp_q;
        int         act;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_count;
    logic [7:0] cmd_data;
    logic       cmd_fill;
    logic [7:0] q;
    logic [1:0] control;
    logic [7:0] data_in;
    logic       sil;
    logic       sir;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int act_cnt = 0;
    int bad = 0;
    int hs_total = 0;
    int done_total = 0;
    vec_t sb[$];
    int   hs_q[$];
    vec_t vecs[13];

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_count      (cmd_count),
        .cmd_data       (cmd_data),
        .cmd_fill       (cmd_fill),
        .reg_q          (q),
        .control        (control),
        .data_in        (data_in),
        .shift_in_left  (sil),
        .shift_in_right (sir),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Universal shift register: right shift takes shift_in_right into the MSB,
    // left shift takes shift_in_left into the LSB.
    always @(posedge clk or negedge rst) begin
        if (!rst) q <= 8'h00;
        else begin
            case (control)
                2'b01:   q <= {sir, q[7:1]};
                2'b10:   q <= {q[6:0], sil};
                2'b11:   q <= data_in;
                default: q <= q;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic el, er;
        vec_t e;
        int h;
        if (!rst) begin
            hs_q.delete();
            act_cnt = 0;
            bad = 0;
        end else begin
            if (control != 2'b00) begin
                act_cnt++;
                if (sb.size() != 0) begin
                    if (control != sb[0].ctrl) bad++;
                    if (control == 2'b11) begin
                        if (data_in !== sb[0].data) bad++;
                    end else begin
                        if (sb[0].op == 2'b11) begin el = 1'b0; er = q[0]; end
                        else begin el = sb[0].fill; er = sb[0].fill; end
                        if (sil !== el || sir !== er) bad++;
                    end
                end
            end
            if (done) begin
                done_total++;
                if (sb.size() == 0 || hs_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    h = hs_q.pop_front();
                    chk("active_cycles", act_cnt, e.act);
                    chk("done_latency", cyc, h + e.act);
                    chk("reg_q", {24'h0, q}, {24'h0, e.exp_q});
                    chk("active_outputs", bad, 0);
                    chk("done_outputs", {19'h0, control, data_in, sil, sir, busy},
                        {19'h0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1});
                end
                act_cnt = 0;
                bad = 0;
            end
            if (cmd_valid && cmd_ready) begin
                hs_q.push_back(cyc + 1);
                hs_total++;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        if (!cmd_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        sb.push_back(v);
        cmd_op = v.op; cmd_count = v.cnt; cmd_data = v.data; cmd_fill = v.fill;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        int hs0, d0;
        vec_t v;
        vecs[0]  = '{2'b00, 4'd0,  8'hA5, 1'b0, 2'b11, 8'hA5, 1};
        vecs[1]  = '{2'b10, 4'd3,  8'h00, 1'b1, 2'b10, 8'h2F, 3};
        vecs[2]  = '{2'b00, 4'd0,  8'h81, 1'b0, 2'b11, 8'h81, 1};
        vecs[3]  = '{2'b11, 4'd1,  8'h00, 1'b0, 2'b01, 8'hC0, 1};
        vecs[4]  = '{2'b00, 4'd7,  8'h81, 1'b1, 2'b11, 8'h81, 1};
        vecs[5]  = '{2'b11, 4'd8,  8'h00, 1'b1, 2'b01, 8'h81, 8};
        vecs[6]  = '{2'b01, 4'd0,  8'h00, 1'b1, 2'b00, 8'h81, 0};
        vecs[7]  = '{2'b01, 4'd15, 8'h00, 1'b0, 2'b01, 8'h00, 8};
        vecs[8]  = '{2'b01, 4'd2,  8'h00, 1'b1, 2'b01, 8'hC0, 2};
        vecs[9]  = '{2'b00, 4'd0,  8'h3C, 1'b0, 2'b11, 8'h3C, 1};
        vecs[10] = '{2'b11, 4'd3,  8'h00, 1'b0, 2'b01, 8'h87, 3};
        vecs[11] = '{2'b10, 4'd9,  8'hFF, 1'b0, 2'b10, 8'h00, 8};
        vecs[12] = '{2'b10, 4'd0,  8'hFF, 1'b1, 2'b00, 8'h00, 0};

        cmd_valid = 0; cmd_op = 0; cmd_count = 0; cmd_data = 0; cmd_fill = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", {19'h0, control, data_in, sil, sir, busy}, 32'h0);
        chk("reset_done_ready", {30'h0, done, cmd_ready}, 32'h0);
        rst = 1'b1;
        #1 chk("ready_before_first_edge", cmd_ready, 0);
        @(posedge clk); #2;
        chk("ready_after_first_edge", cmd_ready, 1);

        for (int i = 0; i < 13; i++) send(vecs[i]);

        // cmd_valid held high: SHL by 2 with fill 1 from 0x00, one command per 4 cycles.
        hs0 = hs_total;
        v = '{2'b10, 4'd2, 8'h00, 1'b1, 2'b10, 8'h03, 2};
        sb.push_back(v);
        v.exp_q = 8'h0F; sb.push_back(v);
        v.exp_q = 8'h3F; sb.push_back(v);
        cmd_op = 2'b10; cmd_count = 4'd2; cmd_fill = 1'b1; cmd_data = 8'h00;
        cmd_valid = 1'b1;
        repeat (12) @(posedge clk);
        #2 cmd_valid = 1'b0;
        chk("held_valid_handshakes", hs_total - hs0, 3);
        wait_idle();

        // Reset in the second cycle of SHL by 5 aborts the command.
        cmd_op = 2'b10; cmd_count = 4'd5; cmd_fill = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        chk("abort_first_shift", control, 2'b10);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("abort_control", control, 2'b00);
        chk("abort_flags", {29'h0, busy, done, cmd_ready}, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("abort_ready_low", cmd_ready, 0);
        @(posedge clk); #2;
        chk("abort_ready_high", cmd_ready, 1);
        d0 = done_total;
        repeat (10) @(posedge clk);
        #2;
        chk("abort_no_done", done_total - d0, 0);
        chk("abort_no_resume", {31'h0, busy}, 0);
        chk("abort_reg_cleared", {24'h0, q}, 0);

        send('{2'b00, 4'd0, 8'h55, 1'b0, 2'b11, 8'h55, 1});
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
